// File: rtl/fa_seq_pkg.sv
// Shared definitions for the full-adder vector sequencer: state encoding,
// vector width and the bit layout of {a, b, cin}.
package fa_seq_pkg;

   localparam int unsigned VEC_W   = 3;
   localparam int unsigned A_BIT   = 2;
   localparam int unsigned B_BIT   = 1;
   localparam int unsigned CIN_BIT = 0;

   localparam logic [VEC_W-1:0] VEC_LAST = 3'd7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } seq_state_t;

   // One stimulus vector as seen by the logic under test
   typedef struct packed {
      logic a;
      logic b;
      logic cin;
   } fa_vec_t;

endpackage : fa_seq_pkg

// File: rtl/fa_golden.sv
// Combinational reference full adder used as the golden model for captured results.
module fa_golden
   import fa_seq_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   output logic             exp_sum,
   output logic             exp_cout
);

   fa_vec_t v;

   always_comb begin
      v.a      = vec[A_BIT];
      v.b      = vec[B_BIT];
      v.cin    = vec[CIN_BIT];
      exp_sum  = v.a ^ v.b ^ v.cin;
      exp_cout = (v.a & v.b) | (v.a & v.cin) | (v.b & v.cin);
   end

endmodule : fa_golden

// File: rtl/fa_vector_sequencer.sv
// Steps all eight {a,b,cin} vectors through the logic under test, holds each for a
// programmable settle time, and accumulates mismatches against the golden adder.
module fa_vector_sequencer
   import fa_seq_pkg::*;
#(
   parameter int unsigned SETTLE_W = 4,
   parameter int unsigned ERR_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                start,
   input  logic [SETTLE_W-1:0] settle_cycles,
   input  logic                dut_sum,
   input  logic                dut_cout,
   output logic [VEC_W-1:0]    vec_out,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ERR_W-1:0]    err_count,
   output logic [VEC_W-1:0]    last_fail_vec
);

   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   seq_state_t          state_q, state_d;
   logic [VEC_W-1:0]    vec_d;
   logic [VEC_W-1:0]    last_d;
   logic [ERR_W-1:0]    err_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic [SETTLE_W-1:0] s_q, s_d;
   logic                busy_d, done_d, pass_d;

   logic                exp_sum, exp_cout;
   logic                mismatch_c;

   fa_golden u_golden (
      .vec      (vec_out),
      .exp_sum  (exp_sum),
      .exp_cout (exp_cout)
   );

   assign mismatch_c = (dut_sum != exp_sum) || (dut_cout != exp_cout);

   // Next-state and next-output decode; dut_* only matter in CAPTURE
   always_comb begin
      state_d = state_q;
      vec_d   = vec_out;
      last_d  = last_fail_vec;
      err_d   = err_count;
      cnt_d   = cnt_q;
      s_d     = s_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               vec_d   = '0;
               err_d   = '0;
               last_d  = '0;
               cnt_d   = settle_cycles;
               s_d     = settle_cycles;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = CAPTURE;
            end else begin
               cnt_d = SETTLE_W'(cnt_q - 1'b1);
            end
         end
         CAPTURE: begin
            if (mismatch_c) begin
               last_d = vec_out;
               if (err_count != ERR_MAX) begin
                  err_d = ERR_W'(err_count + 1'b1);
               end
            end
            if (vec_out == VEC_LAST) begin
               state_d = DONE;
            end else begin
               vec_d   = VEC_W'(vec_out + 1'b1);
               cnt_d   = s_q;
               state_d = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SETTLE) || (state_d == CAPTURE);
      done_d = (state_d == DONE);
      pass_d = done_d && (err_d == '0);
   end

   // State and output registers; ena low freezes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         vec_out       <= '0;
         last_fail_vec <= '0;
         err_count     <= '0;
         cnt_q         <= '0;
         s_q           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
      end else if (ena) begin
         state_q       <= state_d;
         vec_out       <= vec_d;
         last_fail_vec <= last_d;
         err_count     <= err_d;
         cnt_q         <= cnt_d;
         s_q           <= s_d;
         busy          <= busy_d;
         done          <= done_d;
         pass          <= pass_d;
      end
   end

endmodule : fa_vector_sequencer

// File: tb/tb_fa_vector_sequencer.sv
// Directed bench for fa_vector_sequencer: loopback through a golden adder with
// injectable faults, plus a narrow-counter instance to observe saturation.
module tb_fa_vector_sequencer;
   import fa_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, ena, start;
   logic [3:0] settle;
   int         mode;   // 0 correct, 1 cout stuck 0, 2 sum inverted

   logic [2:0] vec1, last1, vec2, last2;
   logic       busy1, done1, pass1, busy2, done2, pass2;
   logic [7:0] err1;
   logic [1:0] err2;
   logic       g1_sum, g1_cout, g2_sum, g2_cout;
   logic       dsum1, dcout1, dsum2, dcout2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fa_golden g1 (.vec(vec1), .exp_sum(g1_sum), .exp_cout(g1_cout));
   fa_golden g2 (.vec(vec2), .exp_sum(g2_sum), .exp_cout(g2_cout));

   always_comb begin
      dsum1  = (mode == 2) ? ~g1_sum : g1_sum;
      dcout1 = (mode == 1) ? 1'b0 : g1_cout;
      dsum2  = ~g2_sum;
      dcout2 = g2_cout;
   end

   fa_vector_sequencer #(.SETTLE_W(4), .ERR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .settle_cycles(settle),
      .dut_sum(dsum1), .dut_cout(dcout1), .vec_out(vec1), .busy(busy1),
      .done(done1), .pass(pass1), .err_count(err1), .last_fail_vec(last1)
   );

   fa_vector_sequencer #(.SETTLE_W(4), .ERR_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .settle_cycles(settle),
      .dut_sum(dsum2), .dut_cout(dcout2), .vec_out(vec2), .busy(busy2),
      .done(done2), .pass(pass2), .err_count(err2), .last_fail_vec(last2)
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Start a run and count edges after the start-sampling edge until done
   task automatic run(input int s, input int pulse_at, input int freeze_at,
                      input int mode_run, output int n);
      logic [2:0] v;
      @(negedge clk);
      settle = 4'(s);
      mode   = mode_run;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("start_busy", int'(busy1), 1);
      chk("start_err", int'(err1), 0);
      chk("start_vec", int'(vec1), 0);
      n = 0;
      while (!done1 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (s == 0 && n < 16 && n % 2 == 0) chk("step_vec", int'(vec1), n / 2);
         if (n == pulse_at) begin
            start  = 1'b1;
            settle = 4'd7;
         end else begin
            start = 1'b0;
         end
         if (n == freeze_at) begin
            v   = vec1;
            ena = 1'b0;
            for (int i = 0; i < 10; i++) begin
               mode = (i % 2 == 0) ? 2 : 1;
               @(posedge clk);
               #1;
               n++;
            end
            chk("frz_vec", int'(vec1), int'(v));
            chk("frz_busy", int'(busy1), 1);
            chk("frz_err", int'(err1), 0);
            mode = mode_run;
            ena  = 1'b1;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n  = 1'b0;
      ena    = 1'b1;
      start  = 1'b0;
      settle = 4'd0;
      mode   = 0;
      #12;
      chk("rst_vec", int'(vec1), 0);
      chk("rst_busy", int'(busy1), 0);
      chk("rst_done", int'(done1), 0);
      chk("rst_pass", int'(pass1), 0);
      chk("rst_err", int'(err1), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Clean loopback, S=0: 2 cycles per vector
      run(0, -1, -1, 0, n);
      chk("t1_cycles", n, 16);
      chk("t1_err", int'(err1), 0);
      chk("t1_pass", int'(pass1), 1);
      chk("t1_last", int'(last1), 0);
      chk("t1_vec", int'(vec1), 7);
      chk("sat_err", int'(err2), 3);
      chk("sat_pass", int'(pass2), 0);
      chk("sat_done", int'(done2), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("t1_done_level", int'(done1), 1);

      // Carry stuck at 0, S=3: vectors 3,5,6,7 fail
      run(3, -1, -1, 1, n);
      chk("t2_cycles", n, 40);
      chk("t2_err", int'(err1), 4);
      chk("t2_last", int'(last1), 7);
      chk("t2_pass", int'(pass1), 0);
      chk("t2_sat_err", int'(err2), 3);

      // Restart from DONE, start re-pulse and settle change mid-run ignored
      run(2, 5, -1, 0, n);
      chk("t4_cycles", n, 32);
      chk("t4_err", int'(err1), 0);
      chk("t4_pass", int'(pass1), 1);

      // Freeze 10 cycles in SETTLE while dut_* toggle
      run(3, -1, 2, 0, n);
      chk("t5_cycles", n, 50);
      chk("t5_err", int'(err1), 0);
      chk("t5_pass", int'(pass1), 1);

      // Async reset during CAPTURE of vector 3 with sum inverted
      @(negedge clk);
      settle = 4'd1;
      mode   = 2;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      chk("t6_pre_vec", int'(vec1), 3);
      chk("t6_pre_err", int'(err1), 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_vec", int'(vec1), 0);
      chk("t6_err", int'(err1), 0);
      chk("t6_last", int'(last1), 0);
      chk("t6_busy", int'(busy1), 0);
      chk("t6_done", int'(done1), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("t6_idle_busy", int'(busy1), 0);
      chk("t6_idle_done", int'(done1), 0);
      chk("t6_idle_vec", int'(vec1), 0);
      chk("t6_idle_err", int'(err1), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fa_vector_sequencer
